// File: rtl/bus_pkg.sv
// Shared bus widths, default address map and device indices for the host crossbar.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bus_pkg;

  localparam int unsigned BUS_AW = 32;
  localparam int unsigned BUS_DW = 32;

  // Default address map: RAM is a 1 MiB window, console and timer are 1 KiB each.
  localparam logic [BUS_AW-1:0] RAM_BASE     = 32'h0010_0000;
  localparam logic [BUS_AW-1:0] RAM_MASK     = 32'hFFF0_0000;
  localparam logic [BUS_AW-1:0] CONSOLE_BASE = 32'h0002_0000;
  localparam logic [BUS_AW-1:0] CONSOLE_MASK = 32'hFFFF_FC00;
  localparam logic [BUS_AW-1:0] TIMER_BASE   = 32'h0003_0000;
  localparam logic [BUS_AW-1:0] TIMER_MASK   = 32'hFFFF_FC00;

  typedef enum logic [1:0] {
    DEV_RAM     = 2'd0,
    DEV_CONSOLE = 2'd1,
    DEV_TIMER   = 2'd2
  } dev_idx_e;

  // One host's request fields bundled so the granted host can be muxed as a unit.
  typedef struct packed {
    logic              we;
    logic [3:0]        be;
    logic [BUS_AW-1:0] addr;
    logic [BUS_DW-1:0] wdata;
  } bus_req_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Address decoder: maps an address to a one-hot device match, its index and a hit flag.
// Latency: purely combinational.
// Backpressure: none; lowest matching device index wins when windows overlap.
module bus_addr_decode #(
  parameter int unsigned                NrDevices = 3,
  parameter int unsigned                IdxW      = (NrDevices > 1) ? $clog2(NrDevices) : 1,
  parameter logic [NrDevices*32-1:0]    DevBase   = {32'h0003_0000, 32'h0002_0000, 32'h0010_0000},
  parameter logic [NrDevices*32-1:0]    DevMask   = {32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFF0_0000}
) (
  input  logic [31:0]          addr,
  output logic [NrDevices-1:0] match_onehot,
  output logic [IdxW-1:0]      match_idx,
  output logic                 match_hit
);

  // Scan from the top so the lowest-index match is the one left standing.
  always_comb begin
    match_onehot = '0;
    match_idx    = '0;
    match_hit    = 1'b0;
    for (int d = NrDevices - 1; d >= 0; d--) begin
      if ((addr & DevMask[32*d +: 32]) == DevBase[32*d +: 32]) begin
        match_idx = IdxW'(d);
        match_hit = 1'b1;
      end
    end
    if (match_hit) begin
      match_onehot[match_idx] = 1'b1;
    end
  end

endmodule

// File: rtl/bus_host_xbar.sv
// Fixed-priority host-to-device bus fabric with address decode and response return.
// Latency: grant same cycle as request, response exactly one cycle after grant.
// Backpressure: losing hosts see gnt=0 and must hold their request; devices cannot stall.
module bus_host_xbar
  import bus_pkg::*;
#(
  parameter int unsigned             NrHosts   = 2,
  parameter int unsigned             NrDevices = 3,
  parameter logic [NrDevices*32-1:0] DevBase   = {TIMER_BASE, CONSOLE_BASE, RAM_BASE},
  parameter logic [NrDevices*32-1:0] DevMask   = {TIMER_MASK, CONSOLE_MASK, RAM_MASK}
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NrHosts-1:0]          host_req_i,
  input  logic [NrHosts-1:0]          host_we_i,
  input  logic [NrHosts*4-1:0]        host_be_i,
  input  logic [NrHosts*BUS_AW-1:0]   host_addr_i,
  input  logic [NrHosts*BUS_DW-1:0]   host_wdata_i,
  output logic [NrHosts-1:0]          host_gnt_o,
  output logic [NrHosts-1:0]          host_rvalid_o,
  output logic [NrHosts*BUS_DW-1:0]   host_rdata_o,
  output logic [NrHosts-1:0]          host_err_o,
  output logic [NrDevices-1:0]        dev_req_o,
  output logic                        dev_we_o,
  output logic [3:0]                  dev_be_o,
  output logic [BUS_AW-1:0]           dev_addr_o,
  output logic [BUS_DW-1:0]           dev_wdata_o,
  input  logic [NrDevices-1:0]        dev_rvalid_i,
  input  logic [NrDevices*BUS_DW-1:0] dev_rdata_i,
  input  logic [NrDevices-1:0]        dev_err_i,
  output logic                        proto_err_o
);

  localparam int unsigned HostIdxW = (NrHosts > 1) ? $clog2(NrHosts) : 1;
  localparam int unsigned DevIdxW  = (NrDevices > 1) ? $clog2(NrDevices) : 1;

  bus_req_t              host_req_s [NrHosts];
  bus_req_t              sel_req;
  logic [BUS_DW-1:0]     dev_rdata_a [NrDevices];
  logic                  gnt_any;
  logic [HostIdxW-1:0]   gnt_idx;
  logic [NrDevices-1:0]  dec_onehot;
  logic [DevIdxW-1:0]    dec_idx;
  logic                  dec_hit;
  logic [BUS_DW-1:0]     rsp_rdata;

  logic                  pending_q;
  logic [HostIdxW-1:0]   host_sel_q;
  logic [DevIdxW-1:0]    dev_sel_q;
  logic                  unmapped_q;

  for (genvar h = 0; h < NrHosts; h++) begin : g_host_unpack
    assign host_req_s[h] = '{we:    host_we_i[h],
                             be:    host_be_i[4*h +: 4],
                             addr:  host_addr_i[BUS_AW*h +: BUS_AW],
                             wdata: host_wdata_i[BUS_DW*h +: BUS_DW]};
  end

  for (genvar d = 0; d < NrDevices; d++) begin : g_dev_unpack
    assign dev_rdata_a[d] = dev_rdata_i[BUS_DW*d +: BUS_DW];
  end

  // Fixed-priority arbiter: the lowest-index requesting host wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int h = NrHosts - 1; h >= 0; h--) begin
      if (host_req_i[h]) begin
        gnt_any = 1'b1;
        gnt_idx = HostIdxW'(h);
      end
    end
  end

  assign host_gnt_o = gnt_any ? (NrHosts'(1) << gnt_idx) : '0;

  // With no grant gnt_idx is 0, so the shared device fields carry host 0.
  assign sel_req     = host_req_s[gnt_idx];
  assign dev_we_o    = sel_req.we;
  assign dev_be_o    = sel_req.be;
  assign dev_addr_o  = sel_req.addr;
  assign dev_wdata_o = sel_req.wdata;

  bus_addr_decode #(
    .NrDevices (NrDevices),
    .IdxW      (DevIdxW),
    .DevBase   (DevBase),
    .DevMask   (DevMask)
  ) u_addr_decode (
    .addr         (sel_req.addr),
    .match_onehot (dec_onehot),
    .match_idx    (dec_idx),
    .match_hit    (dec_hit)
  );

  assign dev_req_o = gnt_any ? dec_onehot : '0;

  // Remember who was granted and where it went, so the next cycle can route the response.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q  <= 1'b0;
      host_sel_q <= '0;
      dev_sel_q  <= '0;
      unmapped_q <= 1'b0;
    end else begin
      pending_q <= gnt_any;
      if (gnt_any) begin
        host_sel_q <= gnt_idx;
        dev_sel_q  <= dec_idx;
        unmapped_q <= ~dec_hit;
      end
    end
  end

  // Sticky flag for a mapped device that failed to answer in its response cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      proto_err_o <= 1'b0;
    end else if (pending_q && !unmapped_q && !dev_rvalid_i[dev_sel_q]) begin
      proto_err_o <= 1'b1;
    end
  end

  // Route the selected device's response back to the granted host; a missing rvalid reads as an error.
  always_comb begin
    host_rvalid_o = '0;
    host_err_o    = '0;
    rsp_rdata     = unmapped_q ? '0 : dev_rdata_a[dev_sel_q];
    if (pending_q) begin
      host_rvalid_o[host_sel_q] = 1'b1;
      host_err_o[host_sel_q]    = unmapped_q | dev_err_i[dev_sel_q] | ~dev_rvalid_i[dev_sel_q];
    end
  end

  assign host_rdata_o = {NrHosts{rsp_rdata}};

endmodule

// File: tb/tb_bus_host_xbar.sv
module tb_bus_host_xbar;

  logic        clk_i;
  logic        rst_ni;
  logic [1:0]  host_req_i;
  logic [1:0]  host_we_i;
  logic [7:0]  host_be_i;
  logic [63:0] host_addr_i;
  logic [63:0] host_wdata_i;
  logic [1:0]  host_gnt_o;
  logic [1:0]  host_rvalid_o;
  logic [63:0] host_rdata_o;
  logic [1:0]  host_err_o;
  logic [2:0]  dev_req_o;
  logic        dev_we_o;
  logic [3:0]  dev_be_o;
  logic [31:0] dev_addr_o;
  logic [31:0] dev_wdata_o;
  logic [2:0]  dev_rvalid_i;
  logic [95:0] dev_rdata_i;
  logic [2:0]  dev_err_i;
  logic        proto_err_o;

  int errors = 0;
  int checks = 0;

  bus_host_xbar dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .host_req_i   (host_req_i),
    .host_we_i    (host_we_i),
    .host_be_i    (host_be_i),
    .host_addr_i  (host_addr_i),
    .host_wdata_i (host_wdata_i),
    .host_gnt_o   (host_gnt_o),
    .host_rvalid_o(host_rvalid_o),
    .host_rdata_o (host_rdata_o),
    .host_err_o   (host_err_o),
    .dev_req_o    (dev_req_o),
    .dev_we_o     (dev_we_o),
    .dev_be_o     (dev_be_o),
    .dev_addr_o   (dev_addr_o),
    .dev_wdata_o  (dev_wdata_o),
    .dev_rvalid_i (dev_rvalid_i),
    .dev_rdata_i  (dev_rdata_i),
    .dev_err_i    (dev_err_i),
    .proto_err_o  (proto_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic drive_host(input int h, input logic req, input logic we, input logic [3:0] be,
                            input logic [31:0] addr, input logic [31:0] wdata);
    host_req_i[h]          = req;
    host_we_i[h]           = we;
    host_be_i[4*h +: 4]    = be;
    host_addr_i[32*h +: 32] = addr;
    host_wdata_i[32*h +: 32] = wdata;
  endtask

  task automatic idle_hosts();
    host_req_i = '0;
    host_we_i  = '0;
    host_be_i  = '0;
    host_addr_i = '0;
    host_wdata_i = '0;
  endtask

  // Reference decode written as address windows rather than base/mask compares.
  function automatic int ref_dev(input logic [31:0] a);
    if (a >= 32'h0010_0000 && a < 32'h0020_0000) return 0;
    if (a >= 32'h0002_0000 && a < 32'h0002_0400) return 1;
    if (a >= 32'h0003_0000 && a < 32'h0003_0400) return 2;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return 32'h0010_0000 | (r & 32'h000F_FFFC);
      1: return 32'h0002_0000 | (r & 32'h0000_03FC);
      2: return 32'h0003_0000 | (r & 32'h0000_03FC);
      3: begin
        case (r[1:0])
          2'd0:    return 32'h0002_0400;
          2'd1:    return 32'h0003_0400;
          2'd2:    return 32'h0020_0000;
          default: return 32'h000F_FFFC;
        endcase
      end
      4: return (r[0]) ? 32'h0002_03FC : 32'h001F_FFFC;
      default: return r;
    endcase
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_hosts();
    dev_rvalid_i = 3'b111;
    dev_err_i = 3'b111;
    dev_rdata_i = {3{32'hDEAD_BEEF}};
    #1;
    checks++; if (host_rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_rvalid: got %b want 00", host_rvalid_o); end
    checks++; if (host_err_o !== 2'b00) begin errors++; $display("FAIL rst_err: got %b want 00", host_err_o); end
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL rst_proto: got %b want 0", proto_err_o); end
    checks++; if (host_gnt_o !== 2'b00 || dev_req_o !== 3'b000) begin errors++; $display("FAIL rst_gnt: got gnt=%b req=%b want 00/000", host_gnt_o, dev_req_o); end
    @(negedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    #1;
    checks++; if (host_rvalid_o !== 2'b00 || proto_err_o !== 1'b0) begin errors++; $display("FAIL unsolicited: got rvalid=%b proto=%b want 00/0", host_rvalid_o, proto_err_o); end
  endtask

  task automatic test_single_write();
    @(negedge clk_i);
    dev_rvalid_i = 3'b000;
    dev_err_i = 3'b000;
    drive_host(0, 1'b1, 1'b1, 4'b0001, 32'h0002_0000, 32'h0000_0041);
    #1;
    checks++; if (host_gnt_o !== 2'b01) begin errors++; $display("FAIL wr_gnt: got %b want 01", host_gnt_o); end
    checks++; if (dev_req_o !== 3'b010) begin errors++; $display("FAIL wr_devreq: got %b want 010", dev_req_o); end
    checks++; if ({dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o} !== {1'b1, 4'b0001, 32'h0002_0000, 32'h0000_0041}) begin
      errors++; $display("FAIL wr_fields: got we=%b be=%b addr=%h wdata=%h want 1/0001/00020000/00000041", dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o);
    end
    @(negedge clk_i);
    idle_hosts();
    dev_rvalid_i = 3'b010;
    #1;
    checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b00) begin errors++; $display("FAIL wr_rsp: got rvalid=%b err=%b want 01/00", host_rvalid_o, host_err_o); end
  endtask

  task automatic test_priority();
    @(negedge clk_i);
    dev_rvalid_i = 3'b000;
    drive_host(0, 1'b1, 1'b0, 4'b1111, 32'h0010_0004, 32'h0);
    drive_host(1, 1'b1, 1'b0, 4'b1111, 32'h0003_0000, 32'h0);
    #1;
    checks++; if (host_gnt_o !== 2'b01 || dev_req_o !== 3'b001) begin errors++; $display("FAIL prio_first: got gnt=%b req=%b want 01/001", host_gnt_o, dev_req_o); end
    checks++; if (dev_addr_o !== 32'h0010_0004) begin errors++; $display("FAIL prio_addr0: got %h want 00100004", dev_addr_o); end
    @(negedge clk_i);
    drive_host(0, 1'b0, 1'b0, 4'b0000, 32'h0, 32'h0);
    dev_rvalid_i = 3'b001;
    #1;
    checks++; if (host_gnt_o !== 2'b10 || dev_req_o !== 3'b100) begin errors++; $display("FAIL prio_second: got gnt=%b req=%b want 10/100", host_gnt_o, dev_req_o); end
    checks++; if (dev_addr_o !== 32'h0003_0000) begin errors++; $display("FAIL prio_addr1: got %h want 00030000", dev_addr_o); end
    checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b00) begin errors++; $display("FAIL prio_rsp0: got rvalid=%b err=%b want 01/00", host_rvalid_o, host_err_o); end
    @(negedge clk_i);
    idle_hosts();
    dev_rvalid_i = 3'b100;
    #1;
    checks++; if (host_rvalid_o !== 2'b10 || host_err_o !== 2'b00) begin errors++; $display("FAIL prio_rsp1: got rvalid=%b err=%b want 10/00", host_rvalid_o, host_err_o); end
  endtask

  task automatic test_read_data();
    @(negedge clk_i);
    dev_rvalid_i = 3'b000;
    drive_host(1, 1'b1, 1'b0, 4'b1111, 32'h0010_0008, 32'h0);
    #1;
    checks++; if (host_gnt_o !== 2'b10 || dev_req_o !== 3'b001) begin errors++; $display("FAIL rd_req: got gnt=%b req=%b want 10/001", host_gnt_o, dev_req_o); end
    @(negedge clk_i);
    idle_hosts();
    dev_rvalid_i = 3'b001;
    dev_rdata_i = {32'h1111_2222, 32'h3333_4444, 32'hCAFE_F00D};
    #1;
    checks++; if (host_rvalid_o !== 2'b10 || host_err_o !== 2'b00) begin errors++; $display("FAIL rd_rsp: got rvalid=%b err=%b want 10/00", host_rvalid_o, host_err_o); end
    checks++; if (host_rdata_o !== {2{32'hCAFE_F00D}}) begin errors++; $display("FAIL rd_data: got %h want cafef00dcafef00d", host_rdata_o); end
  endtask

  task automatic test_unmapped();
    @(negedge clk_i);
    dev_rvalid_i = 3'b000;
    drive_host(0, 1'b1, 1'b0, 4'b1111, 32'h8000_0000, 32'h0);
    #1;
    checks++; if (host_gnt_o !== 2'b01 || dev_req_o !== 3'b000) begin errors++; $display("FAIL um_req: got gnt=%b req=%b want 01/000", host_gnt_o, dev_req_o); end
    @(negedge clk_i);
    idle_hosts();
    dev_rdata_i = {3{32'h5A5A_A5A5}};
    #1;
    checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b01) begin errors++; $display("FAIL um_rsp: got rvalid=%b err=%b want 01/01", host_rvalid_o, host_err_o); end
    checks++; if (host_rdata_o !== 64'h0) begin errors++; $display("FAIL um_data: got %h want 0", host_rdata_o); end
    @(negedge clk_i);
    #1;
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL um_proto: got %b want 0", proto_err_o); end
  endtask

  task automatic test_proto_err();
    @(negedge clk_i);
    dev_rvalid_i = 3'b000;
    dev_err_i = 3'b000;
    drive_host(0, 1'b1, 1'b0, 4'b1111, 32'h0003_0004, 32'h0);
    #1;
    checks++; if (dev_req_o !== 3'b100) begin errors++; $display("FAIL pe_req: got %b want 100", dev_req_o); end
    @(negedge clk_i);
    idle_hosts();
    #1;
    checks++; if (host_rvalid_o !== 2'b01 || host_err_o !== 2'b01 || proto_err_o !== 1'b0) begin
      errors++; $display("FAIL pe_rsp: got rvalid=%b err=%b proto=%b want 01/01/0", host_rvalid_o, host_err_o, proto_err_o);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      dev_rvalid_i = 3'b111;
      #1;
      checks++; if (proto_err_o !== 1'b1) begin errors++; $display("FAIL pe_sticky%0d: got %b want 1", i, proto_err_o); end
    end
    rst_ni = 1'b0;
    #1;
    checks++; if (proto_err_o !== 1'b0) begin errors++; $display("FAIL pe_clear: got %b want 0", proto_err_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic test_random();
    logic        r_req [2];
    logic        r_we [2];
    logic [3:0]  r_be [2];
    logic [31:0] r_addr [2];
    logic [31:0] r_wdata [2];
    int m_pend, m_host, m_dev, m_proto, g, gs, ed;
    logic [1:0]  e_gnt, e_rv, e_err;
    logic [2:0]  e_dreq;
    logic [31:0] e_rdata;
    rst_ni = 1'b0;
    idle_hosts();
    @(negedge clk_i);
    rst_ni = 1'b1;
    m_pend = 0; m_host = 0; m_dev = -1; m_proto = 0;
    for (int h = 0; h < 2; h++) begin
      r_req[h] = 1'b0; r_we[h] = 1'b0; r_be[h] = '0; r_addr[h] = '0; r_wdata[h] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_i);
      for (int h = 0; h < 2; h++) begin
        if (!r_req[h]) begin
          r_req[h]   = ($urandom_range(0, 99) < 55);
          r_we[h]    = 1'($urandom);
          r_be[h]    = 4'($urandom);
          r_addr[h]  = rand_addr();
          r_wdata[h] = $urandom;
        end
        drive_host(h, r_req[h], r_we[h], r_be[h], r_addr[h], r_wdata[h]);
      end
      dev_rvalid_i = 3'($urandom);
      dev_err_i = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b000;
      for (int d = 0; d < 3; d++) dev_rdata_i[32*d +: 32] = $urandom;
      if (m_pend != 0 && m_dev >= 0) dev_rvalid_i[m_dev] = ($urandom_range(0, 15) != 0);
      #1;
      g = -1;
      for (int h = 1; h >= 0; h--) if (r_req[h]) g = h;
      gs = (g >= 0) ? g : 0;
      e_gnt = '0; if (g >= 0) e_gnt[g] = 1'b1;
      ed = (g >= 0) ? ref_dev(r_addr[g]) : -1;
      e_dreq = '0; if (ed >= 0) e_dreq[ed] = 1'b1;
      e_rv = '0; e_err = '0; e_rdata = '0;
      if (m_pend != 0) begin
        e_rv[m_host] = 1'b1;
        if (m_dev >= 0) begin
          e_rdata = dev_rdata_i[32*m_dev +: 32];
          e_err[m_host] = dev_err_i[m_dev] | ~dev_rvalid_i[m_dev];
        end else begin
          e_err[m_host] = 1'b1;
        end
      end
      checks++; if (host_gnt_o !== e_gnt || dev_req_o !== e_dreq) begin
        errors++; $display("FAIL rnd_req c%0d: got gnt=%b req=%b want %b/%b", c, host_gnt_o, dev_req_o, e_gnt, e_dreq);
      end
      checks++; if ({dev_we_o, dev_be_o, dev_addr_o, dev_wdata_o} !== {r_we[gs], r_be[gs], r_addr[gs], r_wdata[gs]}) begin
        errors++; $display("FAIL rnd_fields c%0d: got addr=%h wdata=%h want %h/%h", c, dev_addr_o, dev_wdata_o, r_addr[gs], r_wdata[gs]);
      end
      checks++; if (host_rvalid_o !== e_rv || host_err_o !== e_err) begin
        errors++; $display("FAIL rnd_rsp c%0d: got rvalid=%b err=%b want %b/%b", c, host_rvalid_o, host_err_o, e_rv, e_err);
      end
      if (m_pend != 0) begin
        checks++; if (host_rdata_o !== {2{e_rdata}}) begin errors++; $display("FAIL rnd_data c%0d: got %h want %h", c, host_rdata_o, {2{e_rdata}}); end
      end
      checks++; if (proto_err_o !== 1'(m_proto)) begin errors++; $display("FAIL rnd_proto c%0d: got %b want %0d", c, proto_err_o, m_proto); end
      if (m_pend != 0 && m_dev >= 0 && !dev_rvalid_i[m_dev]) m_proto = 1;
      m_pend = (g >= 0) ? 1 : 0;
      m_host = gs;
      m_dev  = ed;
      if (g >= 0) r_req[g] = 1'b0;
    end
    @(negedge clk_i);
    idle_hosts();
    @(negedge clk_i);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addrs [4];
    addrs[0] = 32'h0010_0000; addrs[1] = 32'h0002_0004; addrs[2] = 32'h0003_0008; addrs[3] = 32'h0010_0010;
    rst_ni = 1'b0;
    idle_hosts();
    @(negedge clk_i);
    rst_ni = 1'b1;
    dev_rvalid_i = 3'b111;
    dev_err_i = 3'b000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      drive_host(0, 1'b1, 1'b0, 4'b1111, addrs[i], 32'h0);
      #1;
      checks++; if (host_gnt_o !== 2'b01) begin errors++; $display("FAIL b2b_gnt%0d: got %b want 01", i, host_gnt_o); end
      checks++; if (host_rvalid_o !== ((i == 0) ? 2'b00 : 2'b01)) begin errors++; $display("FAIL b2b_rv%0d: got %b", i, host_rvalid_o); end
    end
    @(negedge clk_i);
    drive_host(0, 1'b1, 1'b0, 4'b1111, addrs[3], 32'h0);
    rst_ni = 1'b0;
    #1;
    checks++; if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00 || proto_err_o !== 1'b0) begin
      errors++; $display("FAIL b2b_drop: got rvalid=%b err=%b proto=%b want 00/00/0", host_rvalid_o, host_err_o, proto_err_o);
    end
    @(negedge clk_i);
    idle_hosts();
    rst_ni = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      #1;
      checks++; if (host_rvalid_o !== 2'b00 || host_err_o !== 2'b00 || host_gnt_o !== 2'b00 || dev_req_o !== 3'b000) begin
        errors++; $display("FAIL b2b_after%0d: got rvalid=%b err=%b gnt=%b req=%b want all 0", i, host_rvalid_o, host_err_o, host_gnt_o, dev_req_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_priority();
    test_read_data();
    test_unmapped();
    test_proto_err();
    test_random();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_host_xbar.md
Name: bus_host_xbar

Overview:
- Simple single-cycle bus fabric feeding the simulation console, RAM and timer slaves.
- Arbitrates between bus hosts by fixed priority (core data port, debug/loader) and decodes the address to one device.
- Forwards the request to that device and returns its one-cycle-later response to the granted host.
- Flags unmapped accesses and device protocol violations.

Parameters:
- NrHosts, 2, number of bus hosts; index 0 has highest priority.
- NrDevices, 3, number of slave devices.
- DevBase, {32'h0003_0000, 32'h0002_0000, 32'h0010_0000}, packed NrDevices*32 base addresses; device d uses slice [32*d +: 32].
- DevMask, {32'hFFFF_FC00, 32'hFFFF_FC00, 32'hFFF0_0000}, packed address masks, same slicing.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- host_req_i  in  NrHosts  request per host
- host_we_i  in  NrHosts  write enable
- host_be_i  in  NrHosts*4  byte enables
- host_addr_i  in  NrHosts*32  address
- host_wdata_i  in  NrHosts*32  write data
- host_gnt_o  out  NrHosts  grant, combinational, same cycle as request
- host_rvalid_o  out  NrHosts  response valid, one cycle after grant
- host_rdata_o  out  NrHosts*32  read data; all hosts see the same value, qualified by rvalid
- host_err_o  out  NrHosts  response error, qualified by rvalid
- dev_req_o  out  NrDevices  one-hot request to the selected device
- dev_we_o  out  1  shared write enable
- dev_be_o  out  4  shared byte enables
- dev_addr_o  out  32  shared address
- dev_wdata_o  out  32  shared write data
- dev_rvalid_i  in  NrDevices  device response valid
- dev_rdata_i  in  NrDevices*32  device read data
- dev_err_i  in  NrDevices  device error
- proto_err_o  out  1  sticky: a device missed its response cycle

Behaviour:
- Clocking/reset: one clock, clk_i; reset is asynchronous, active-low on rst_ni.
- Reset values: pending_q=0, host_sel_q=0, dev_sel_q=0, unmapped_q=0, proto_err_o=0; hence all host_rvalid_o=0 and host_err_o=0.
- Arbitration: combinational. The lowest-index host with req=1 gets gnt=1; all others gnt=0. No fairness, and a losing host must hold its request.
- Decode:
  - Device d matches when (addr & DevMask[d]) == DevBase[d]; the lowest matching index wins.
  - No match means unmapped.
- Request forwarding:
  - dev_req_o[d]=1 only for the matched device of the granted request.
  - The shared dev_* fields always carry the granted host's fields; they are the host-0 fields when nothing is granted.
- Capture at posedge on any grant: pending_q<=1, host_sel_q<=granted index, dev_sel_q<=matched index, unmapped_q<=no match. With no grant, pending_q<=0.
- Response, cycle N+1 for a grant in cycle N:
  - host_rvalid_o[host_sel_q]=pending_q; all other host rvalid bits are 0.
  - host_rdata_o = unmapped_q ? 32'h0 : dev_rdata_i[dev_sel_q].
  - host_err_o[host_sel_q] = unmapped_q | dev_err_i[dev_sel_q] | ~dev_rvalid_i[dev_sel_q].
- Protocol error: if pending_q and not unmapped_q and dev_rvalid_i[dev_sel_q]=0, then proto_err_o<=1 and stays 1 until reset. Rvalid is still returned to the host, with err=1.
- Pipelining: a new grant is allowed in the same cycle as the previous response, so full throughput is one transaction per cycle. The response registers update every cycle.
- Unsolicited dev_rvalid_i while pending_q=0 is ignored (no host rvalid).
- Reset mid-transaction: the pending response is dropped; no rvalid appears after reset is released.

Decomposition:
- Package bus_pkg holds:
  - BUS_AW=32, BUS_DW=32;
  - the default address-map constants (RAM_BASE/MASK, CONSOLE_BASE/MASK, TIMER_BASE/MASK);
  - the device index enum DEV_RAM=0, DEV_CONSOLE=1, DEV_TIMER=2.
- One sub-module, bus_addr_decode: combinational address to {onehot match, index, hit}, parameterised on NrDevices/DevBase/DevMask.
- Arbiter stays inline as a priority loop.

Test Plan:
- Host0 write 0x0002_0000 wdata=0x41 be=4'b0001 -> same cycle gnt[0]=1, dev_req_o=3'b010; next cycle host_rvalid_o[0]=1, err=0.
- Host0 and host1 both request (0x0010_0004, 0x0003_0000) -> gnt=2'b01, dev_req_o=3'b001. Host1 holds its request and is granted next cycle: dev_req_o=3'b100, response to host1 one cycle later.
- Host1 read 0x0010_0008 with RAM returning rdata 0xCAFEF00D, rvalid=1 -> host_rvalid_o[1]=1, host_rdata_o=0xCAFEF00D, err=0.
- Read 0x8000_0000 (unmapped) -> dev_req_o=0; next cycle rvalid=1, rdata=0, err=1; proto_err_o stays 0.
- Timer access where the timer withholds rvalid -> host rvalid=1 with err=1; proto_err_o=1 from the following cycle and it persists until rst_ni is low.
- Back-to-back reads on 4 consecutive cycles, with reset asserted after the 3rd grant -> 2 responses delivered, the 3rd dropped, the 4th never granted, all outputs at reset values.
